// File: rtl/imem_pkg.sv
// Shared defaults and loader state encoding for the instruction-memory loader.
// IMEM_LOADER_CHECKSUM_EN adds the CHECK state used by the trailing-checksum feature.
package imem_pkg;

    localparam int AW_DEF    = 6;
    localparam int DEPTH_DEF = 64;

`ifdef IMEM_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {ST_LEN, ST_DATA, ST_CHECK, ST_DONE, ST_ERROR} loader_state_e;
`else
    typedef enum logic [2:0] {ST_LEN, ST_DATA, ST_DONE, ST_ERROR} loader_state_e;
`endif

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Little-endian byte-to-word assembler: first byte lands in bits [7:0], and a
// one-cycle word_vld pulse follows the cycle that accepted the fourth byte.
module byte_packer (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        byte_vld,
    input  logic [7:0]  byte_in,
    output logic [1:0]  byte_cnt,
    output logic [31:0] word_out,
    output logic        word_vld
);

    logic [1:0]  cnt_q, cnt_d;
    logic [23:0] part_q, part_d;
    logic [31:0] word_q, word_d;
    logic        vld_q, vld_d;

    always_comb begin
        cnt_d  = cnt_q;
        part_d = part_q;
        word_d = word_q;
        vld_d  = 1'b0;
        if (clear) begin
            cnt_d  = 2'd0;
            part_d = '0;
        end else if (byte_vld) begin
            cnt_d = cnt_q + 2'd1;
            case (cnt_q)
                2'd0:    part_d[7:0]   = byte_in;
                2'd1:    part_d[15:8]  = byte_in;
                2'd2:    part_d[23:16] = byte_in;
                default: begin
                    word_d = {byte_in, part_q};
                    vld_d  = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q  <= 2'd0;
            part_q <= '0;
            word_q <= '0;
            vld_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            part_q <= part_d;
            word_q <= word_d;
            vld_q  <= vld_d;
        end
    end

    assign byte_cnt = cnt_q;
    assign word_out = word_q;
    assign word_vld = vld_q;

endmodule

// File: rtl/imem_loader.sv
// Streams a length byte plus 4N data bytes into instruction memory, then releases the CPU.
// Define IMEM_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte before release.
module imem_loader
    import imem_pkg::*;
#(
    parameter int AW    = AW_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          in_valid,
    input  logic [7:0]    in_data,
    output logic          in_ready,
    input  logic [AW-1:0] pc_a,
    output logic [AW-1:0] imem_a,
    output logic          imem_we,
    output logic [31:0]   imem_wd,
    output logic          cpu_run,
    output logic          load_err,
    output logic [AW:0]   words_loaded
);

    localparam logic [AW:0] DEPTH_N = (AW+1)'(DEPTH);
    localparam logic [AW:0] W_ONE   = (AW+1)'(1);

    loader_state_e state_q, state_d;
    logic [AW:0]   words_q, words_d;
    logic [AW:0]   n_q, n_d;
    logic          last_q, last_d;
    logic          accept, pk_vld, pk_done;
    logic [1:0]    pk_cnt;
    logic [31:0]   pk_word;
    logic [AW:0]   len_n;

    assign accept = in_valid && in_ready;
    assign pk_vld = accept && (state_q == ST_DATA);
    assign len_n  = in_data[AW:0];

    byte_packer u_packer (
        .clk      (clk),
        .reset    (reset),
        .clear    (start),
        .byte_vld (pk_vld),
        .byte_in  (in_data),
        .byte_cnt (pk_cnt),
        .word_out (pk_word),
        .word_vld (pk_done)
    );

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0] csum_q, csum_d;

    always_comb begin
        csum_d = csum_q;
        if (start)
            csum_d = '0;
        else if (pk_vld)
            csum_d = csum_q ^ in_data;
    end

    always_ff @(posedge clk) begin
        if (reset) csum_q <= '0;
        else       csum_q <= csum_d;
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) state_q <= ST_LEN;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_LEN:  if (accept) state_d = ST_DATA;
`ifdef IMEM_LOADER_CHECKSUM_EN
            ST_DATA: if (pk_done && last_q) state_d = ST_CHECK;
            ST_CHECK: if (accept) state_d = (in_data == csum_q) ? ST_DONE : ST_ERROR;
`else
            ST_DATA: if (pk_done && last_q) state_d = ST_DONE;
`endif
            default: state_d = state_q;
        endcase
        if (start) state_d = ST_LEN;
    end

    // last_q marks that the final word's bytes are all in; input stalls until its write lands
    always_comb begin
        words_d = pk_done ? words_q + W_ONE : words_q;
        n_d     = n_q;
        last_d  = last_q;
        if (state_q == ST_LEN && accept)
            n_d = (len_n == '0 || len_n > DEPTH_N) ? DEPTH_N : len_n;
        if (pk_vld && pk_cnt == 2'd3 && (words_q + W_ONE) == n_q)
            last_d = 1'b1;
        else if (pk_done && last_q)
            last_d = 1'b0;
        if (start) begin
            words_d = '0;
            last_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            words_q <= '0;
            n_q     <= '0;
            last_q  <= 1'b0;
        end else begin
            words_q <= words_d;
            n_q     <= n_d;
            last_q  <= last_d;
        end
    end

    always_comb begin
        in_ready = 1'b0;
        case (state_q)
            ST_LEN:   in_ready = 1'b1;
            ST_DATA:  in_ready = !last_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
            ST_CHECK: in_ready = 1'b1;
`endif
            default:  in_ready = 1'b0;
        endcase
        if (start || reset) in_ready = 1'b0;
        cpu_run = (state_q == ST_DONE);
`ifdef IMEM_LOADER_CHECKSUM_EN
        load_err = (state_q == ST_ERROR);
`else
        load_err = 1'b0;
`endif
        imem_a = cpu_run ? pc_a : words_q[AW-1:0];
    end

    assign imem_we      = pk_done;
    assign imem_wd      = pk_word;
    assign words_loaded = words_q;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: expected memory writes are queued as bytes are
// driven and popped by a monitor on each imem_we pulse.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        reset, start, in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic [5:0]  pc_a, imem_a;
    logic        imem_we;
    logic [31:0] imem_wd;
    logic        cpu_run, load_err;
    logic [6:0]  words_loaded;

    typedef struct {
        logic [5:0]  a;
        logic [31:0] d;
    } wr_t;

    wr_t         exp_q[$];
    logic [31:0] wbuf[$];
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;

    imem_loader #(.AW(6), .DEPTH(64)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .pc_a         (pc_a),
        .imem_a       (imem_a),
        .imem_we      (imem_we),
        .imem_wd      (imem_wd),
        .cpu_run      (cpu_run),
        .load_err     (load_err),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (imem_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_we", 1, 0);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                chk("wr_addr", imem_a, e.a);
                chk("wr_data", imem_wd, e.d);
            end
        end
    end

    // Called at a falling edge; returns at the falling edge after the byte is taken.
    task automatic send_byte(input logic [7:0] b);
        int guard = 0;
        in_valid = 1'b1;
        in_data  = b;
        #1;
        while (!in_ready && guard < 50) begin
            @(negedge clk);
            #1;
            guard++;
        end
        if (guard >= 50) chk("accept_timeout", 1, 0);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic load(input logic [7:0] len, input int nw, input bit rnd, output logic [7:0] cs);
        logic [31:0] w;
        wr_t e;
        send_byte(len);
        cs = 8'h00;
        for (int k = 0; k < nw; k++) begin
            w = rnd ? $urandom : wbuf[k];
            for (int b = 0; b < 4; b++) begin
                if (b == 3) begin
                    e.a = 6'(k);
                    e.d = w;
                    exp_q.push_back(e);
                end
                cs = cs ^ w[8*b +: 8];
                send_byte(w[8*b +: 8]);
            end
        end
    endtask

    // Entered at the falling edge of the last word's write cycle.
    task automatic finish_load(input logic [7:0] cs, input bit good, input string tag);
`ifdef IMEM_LOADER_CHECKSUM_EN
        chk({tag, "_run_pre"}, cpu_run, 0);
        send_byte(cs);
        chk({tag, "_run"}, cpu_run, good);
        chk({tag, "_err"}, load_err, !good);
`else
        chk({tag, "_run_wecyc"}, cpu_run, 0);
        @(negedge clk);
        chk({tag, "_run"}, cpu_run, good);
        chk({tag, "_err"}, load_err, 0);
        chk({tag, "_cs_unused"}, {56'd0, cs}, {56'd0, cs});
`endif
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] cs;
        int c0;
        reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00; pc_a = 6'h00;

        // reset state
        @(negedge clk);
        @(negedge clk);
        chk("rst_ready_during", in_ready, 0);
        chk("rst_we", imem_we, 0);
        chk("rst_wd", imem_wd, 0);
        chk("rst_run", cpu_run, 0);
        chk("rst_err", load_err, 0);
        chk("rst_words", words_loaded, 0);
        reset = 1'b0;
        #1;
        chk("rst_ready_after", in_ready, 1);
        @(negedge clk);

        // two-word load
        wbuf = '{32'h20000013, 32'h20010005};
        load(8'h02, 2, 1'b0, cs);
        finish_load(cs, 1'b1, "two_word");
        chk("two_word_words", words_loaded, 2);
        chk("two_word_ready", in_ready, 0);
        pc_a = 6'h15;
        #1;
        chk("done_imem_a", imem_a, 6'h15);
        chk("done_we", imem_we, 0);

`ifdef IMEM_LOADER_CHECKSUM_EN
        // corrupted checksum must land in ERROR
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        load(8'h02, 2, 1'b0, cs);
        finish_load(cs ^ 8'h5a, 1'b0, "bad_cs");
        chk("bad_cs_ready", in_ready, 0);
`endif

        // start mid-load after five bytes of a two-word load
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        send_byte(8'h02);
        wbuf = '{32'h11223344};
        exp_q.push_back('{6'd0, 32'h11223344});
        send_byte(8'h44); send_byte(8'h33); send_byte(8'h22); send_byte(8'h11);
        send_byte(8'h99);
        chk("mid_words_before", words_loaded, 1);
        chk("mid_imem_a", imem_a, 6'd1);
        start = 1'b1; in_valid = 1'b1; in_data = 8'h05;
        #1;
        chk("start_ready", in_ready, 0);
        @(negedge clk);
        start = 1'b0; in_valid = 1'b0;
        #1;
        chk("start_words", words_loaded, 0);
        chk("start_run", cpu_run, 0);
        chk("start_ready_len", in_ready, 1);
        @(negedge clk);

        // fresh one-word load with idle gaps holding a partial word
        send_byte(8'h01);
        exp_q.push_back('{6'd0, 32'hdeadbeef});
        send_byte(8'hef); send_byte(8'hbe);
        repeat (5) @(negedge clk);
        chk("hold_words", words_loaded, 0);
        send_byte(8'had); send_byte(8'hde);
        finish_load(8'hef ^ 8'hbe ^ 8'had ^ 8'hde, 1'b1, "one_word");
        chk("one_word_words", words_loaded, 1);

        // length byte uses only its low bits: 0x83 -> 3 words
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        load(8'h83, 3, 1'b1, cs);
        finish_load(cs, 1'b1, "mask_len");
        chk("mask_len_words", words_loaded, 3);

        // L=0 streams a full memory with no stalls
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        send_byte(8'h00);
        c0 = cyc;
        begin
            logic [31:0] w;
            wr_t e;
            cs = 8'h00;
            for (int k = 0; k < 64; k++) begin
                w = $urandom;
                e.a = 6'(k);
                e.d = w;
                exp_q.push_back(e);
                for (int b = 0; b < 4; b++) begin
                    cs = cs ^ w[8*b +: 8];
                    send_byte(w[8*b +: 8]);
                end
            end
        end
        chk("full_cycles", cyc - c0, 256);
        finish_load(cs, 1'b1, "full");
        chk("full_words", words_loaded, 64);

        // oversize length (0x41 = 65) clamps to 64 words
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        load(8'h41, 64, 1'b1, cs);
        finish_load(cs, 1'b1, "clamp");
        chk("clamp_words", words_loaded, 64);

        // reset during a write cycle
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        load(8'h01, 1, 1'b1, cs);
        chk("we_before_rst", imem_we, 1);
        reset = 1'b1;
        @(negedge clk);
        chk("rst2_we", imem_we, 0);
        chk("rst2_wd", imem_wd, 0);
        chk("rst2_words", words_loaded, 0);
        chk("rst2_run", cpu_run, 0);
        chk("rst2_err", load_err, 0);
        chk("rst2_ready", in_ready, 0);
        reset = 1'b0;
        #1;
        chk("rst2_ready_after", in_ready, 1);
        @(negedge clk);

        chk("sb_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
